simodense_wb_bridge: RTL
========================

Name: simodense_wb_bridge

Overview:
- Sits between the Simodense System block-burst data port (addrD/enD/weD/doutD/dinD/accR/accW/readyD) and the processorci Wishbone-style core bus (core_cyc/stb/we/wstrb/addr/data/ack).
- Converts one cache-block read or write into a sequence of single 32-bit bus beats.
- On reads, it reassembles the returned words into subblocks. On writes, it splits subblocks into words.
- A bus watchdog aborts a beat that is never acknowledged.

Parameters:
- SUBBLOCKS, 4, subblocks per cache block; power of two, ≥2.
- SUB_W, 64, subblock width in bits; multiple of 32.
- TIMEOUT, 1024, cycles a beat may wait for core_ack before it is aborted; ≥2.

Ports:
- sys_clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- addrD  in  32  block address; the low log2(SUBBLOCKS*SUB_W/8) bits are ignored.
- enD  in  1  request strobe, sampled only while readyD=1.
- weD  in  1  1=block write, 0=block read; sampled with enD.
- doutD  in  SUB_W  write subblock data.
- doutDstrobe  in  log2(SUBBLOCKS)  index of the subblock currently on doutD.
- dinD  out  SUB_W  read subblock data.
- dinDstrobe  out  log2(SUBBLOCKS)  index of the subblock on dinD.
- accR  out  1  one-cycle pulse: dinD/dinDstrobe valid.
- accW  out  1  one-cycle pulse: the subblock on doutD has been captured.
- readyD  out  1  idle; can accept a request.
- core_cyc, core_stb  out  1  bus cycle and strobe, always equal.
- core_we  out  1  bus write.
- core_wstrb  out  4  byte strobes.
- core_addr  out  32  byte address.
- core_data_out  out  32  write data.
- core_data_in  in  32  read data.
- core_ack  in  1  beat acknowledge.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n=0 at an edge) forces the following at the next edge, including mid-burst:
  - state IDLE; readyD=1.
  - core_cyc=core_stb=core_we=0, core_wstrb=0, core_addr=0, core_data_out=0.
  - dinD=0, dinDstrobe=0, accR=accW=0, err=0.
  - An in-flight beat is abandoned; no accR/accW is issued for it.
- Word arithmetic:
  - W = SUB_W/32 words per subblock; N = SUBBLOCKS*W beats per block.
  - base = addrD with the low log2(N*4) bits cleared.
  - Beat b uses core_addr = base + 4*b, mod 2^32.
  - Word j of subblock k is bits [32j+31:32j] and is beat k*W+j; the lowest word sits at the lowest address.
- States: IDLE, LOAD, REQ, GAP, DLVR.
- IDLE: readyD=1. enD=1 latches base/weD, sets b=0 and readyD=0 at the next edge, then goes to LOAD if weD=1, else REQ.
  - enD while readyD=0 is ignored.
- LOAD (write only, entered when b%W==0):
  - Captures doutD into the shift register; accW=1 for this one cycle; goes to REQ.
  - If doutDstrobe != b/W, err is set and the write still proceeds.
- REQ:
  - core_cyc=core_stb=1, core_wstrb=4'hF, core_we=weD.
  - core_addr and core_data_out are stable until ack.
  - core_ack=1 ends the beat. On reads, the word is stored into slot b%W.
  - Watchdog counts cycles in REQ. When it reaches TIMEOUT without ack: set err, treat as ack with data 0.
- GAP: core_cyc=core_stb=0 for exactly one cycle after every ack. Then, in priority order:
  - read, b%W==W-1 → DLVR;
  - b==N-1 → IDLE;
  - write, (b+1)%W==0 → LOAD;
  - else → REQ.
  - b increments on leaving GAP.
- DLVR (read): accR=1 for one cycle, dinD = assembled subblock, dinDstrobe = b/W. Then IDLE if b==N-1, else REQ.
- readyD returns to 1 on the cycle after the last beat's GAP (write) or DLVR (read).
- dinD and dinDstrobe hold their values until the next DLVR.
- err is cleared only by reset.
- A core_ack that arrives outside REQ is ignored.

Test Plan:
- Read, addrD=0x0000_1234, ack 1 cycle after stb, data = address+0x100:
  - beats at 0x1220..0x123C in order;
  - accR pulses with dinDstrobe 0,1,2,3;
  - subblock 0 = 0x0000_1324_0000_1320;
  - readyD=1 after the 4th accR; err=0.
- Write, addrD=0x8000, subblock k = {k+0x10, k}; System advances doutDstrobe after each accW:
  - 8 beats, core_we=1, wstrb=4'hF;
  - data 0,0x10,1,0x11,… at 0x8000..0x801C;
  - 4 accW pulses.
- Wrap-around, read at addrD=0xFFFF_FFE0 → last beat at 0xFFFF_FFFC, with no carry beyond 32 bits.
- Timeout, TIMEOUT=8, no ack on beat 3 of a read:
  - stb drops after 8 cycles in REQ; err=1;
  - subblock 1 upper word = 0; the burst completes.
- Reset mid-burst, rst_n=0 during beat 5 of a write:
  - next edge: core_cyc=0, readyD=1, no further accW;
  - a new read then runs normally.
- enD=1 pulsed while readyD=0 and doutDstrobe mismatch (2 given at LOAD k=1):
  - the second request is ignored; err=1; the write data is still issued.

Source files
------------

// File: rtl/simodense_wb_bridge.sv
// Bridges the Simodense block-burst data port to a single-beat Wishbone-style core bus.
// Splits cache-block writes into words and reassembles read words into subblocks.
module simodense_wb_bridge #(
   parameter int unsigned SUBBLOCKS = 4,
   parameter int unsigned SUB_W     = 64,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                         sys_clk,
   input  logic                         rst_n,
   input  logic [31:0]                  addrD,
   input  logic                         enD,
   input  logic                         weD,
   input  logic [SUB_W-1:0]             doutD,
   input  logic [$clog2(SUBBLOCKS)-1:0] doutDstrobe,
   output logic [SUB_W-1:0]             dinD,
   output logic [$clog2(SUBBLOCKS)-1:0] dinDstrobe,
   output logic                         accR,
   output logic                         accW,
   output logic                         readyD,
   output logic                         core_cyc,
   output logic                         core_stb,
   output logic                         core_we,
   output logic [3:0]                   core_wstrb,
   output logic [31:0]                  core_addr,
   output logic [31:0]                  core_data_out,
   input  logic [31:0]                  core_data_in,
   input  logic                         core_ack,
   output logic                         err
);

   localparam int unsigned W   = SUB_W / 32;
   localparam int unsigned N   = SUBBLOCKS * W;
   localparam int unsigned BW  = $clog2(N);
   localparam int unsigned IW  = $clog2(SUBBLOCKS);
   localparam int unsigned TW  = $clog2(TIMEOUT);
   localparam int unsigned OFS = $clog2(N * 4);
   localparam logic [31:0] BASE_MASK = ~((32'd1 << OFS) - 32'd1);

   typedef enum logic [2:0] {StIdle, StLoad, StReq, StGap, StDlvr} state_e;

   state_e           state_q, state_d;
   logic [31:0]      base_q, base_d;
   logic             we_q, we_d;
   logic [BW-1:0]    b_q, b_d;
   logic [TW-1:0]    wdog_q, wdog_d;
   logic [SUB_W-1:0] wbuf_q, wbuf_d;
   logic [SUB_W-1:0] rbuf_q, rbuf_d;
   logic [SUB_W-1:0] din_q, din_d;
   logic [IW-1:0]    dstb_q, dstb_d;
   logic             err_q, err_d;

   logic [BW-1:0] word_idx;
   logic [IW-1:0] sub_idx;
   logic          last_word, last_beat;

   assign word_idx  = b_q % BW'(W);
   assign sub_idx   = IW'(b_q / BW'(W));
   assign last_word = (word_idx == BW'(W - 1));
   assign last_beat = (b_q == BW'(N - 1));

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         base_q  <= '0;
         we_q    <= 1'b0;
         b_q     <= '0;
         wdog_q  <= '0;
         wbuf_q  <= '0;
         rbuf_q  <= '0;
         din_q   <= '0;
         dstb_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         we_q    <= we_d;
         b_q     <= b_d;
         wdog_q  <= wdog_d;
         wbuf_q  <= wbuf_d;
         rbuf_q  <= rbuf_d;
         din_q   <= din_d;
         dstb_q  <= dstb_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      we_d    = we_q;
      b_d     = b_q;
      wdog_d  = '0;
      wbuf_d  = wbuf_q;
      rbuf_d  = rbuf_q;
      din_d   = din_q;
      dstb_d  = dstb_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (enD) begin
               base_d  = addrD & BASE_MASK;
               we_d    = weD;
               b_d     = '0;
               state_d = weD ? StLoad : StReq;
            end
         end
         StLoad: begin
            wbuf_d = doutD;
            if (doutDstrobe != sub_idx) err_d = 1'b1;
            state_d = StReq;
         end
         StReq: begin
            // An expired watchdog completes the beat as if acked with zero data.
            if (core_ack) begin
               if (!we_q) rbuf_d[32*word_idx +: 32] = core_data_in;
               state_d = StGap;
            end else if (wdog_q == TW'(TIMEOUT - 1)) begin
               if (!we_q) rbuf_d[32*word_idx +: 32] = 32'h0;
               err_d   = 1'b1;
               state_d = StGap;
            end else begin
               wdog_d = wdog_q + TW'(1);
            end
         end
         StGap: begin
            if (!we_q && last_word) begin
               din_d   = rbuf_q;
               dstb_d  = sub_idx;
               state_d = StDlvr;
            end else if (last_beat) begin
               state_d = StIdle;
            end else begin
               b_d     = b_q + BW'(1);
               state_d = (we_q && last_word) ? StLoad : StReq;
            end
         end
         StDlvr: begin
            if (last_beat) begin
               state_d = StIdle;
            end else begin
               b_d     = b_q + BW'(1);
               state_d = StReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign readyD        = (state_q == StIdle);
   assign accW          = (state_q == StLoad);
   assign accR          = (state_q == StDlvr);
   assign core_cyc      = (state_q == StReq);
   assign core_stb      = (state_q == StReq);
   assign core_we       = (state_q == StReq) && we_q;
   assign core_wstrb    = (state_q == StReq) ? 4'hF : 4'h0;
   assign core_addr     = base_q + 32'({b_q, 2'b00});
   assign core_data_out = wbuf_q[32*word_idx +: 32];
   assign dinD          = din_q;
   assign dinDstrobe    = dstb_q;
   assign err           = err_q;

endmodule
